// File: rtl/ctrl_edicion_teclado_if.sv
// Keyboard edit controller bus: the received scan-code strobe from the PS/2
// receiver and the edit context/strokes driven towards the field counters.
// The master side is whoever supplies bytes; the slave side is the controller.
interface ctrl_edicion_teclado_if #(
  parameter int N = 8,
  parameter int P = 2
);
  logic         rx_done;
  logic [N-1:0] rx_data;
  logic         f1;
  logic         f3;
  logic [P-1:0] posicion;
  logic         en_codigo;
  logic [N-1:0] key_code;

  modport master (
    output rx_done, rx_data,
    input  f1, f3, posicion, en_codigo, key_code
  );

  modport slave (
    input  rx_done, rx_data,
    output f1, f3, posicion, en_codigo, key_code
  );
endinterface

// File: rtl/ctrl_edicion_teclado.sv
// Keyboard edit controller for the RTC/timer display.
// Filters the PS/2 byte stream (break F0 / extended E0 prefixes), selects the
// edit mode (F1 = clock, F3 = timer), moves the field cursor and issues
// single-cycle up/down strokes. Idle edits fall back to IDLE after TIMEOUT
// cycles without a make code. All outputs come straight from flops.
module ctrl_edicion_teclado #(
  parameter int N       = 8,
  parameter int P       = 2,
  parameter int NUM_POS = 3,
  parameter int TW      = 30,
  parameter int TIMEOUT = 500_000_000
) (
  input logic                   clk,
  input logic                   rst,
  ctrl_edicion_teclado_if.slave bus
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] EDIT_RELOJ = 2'd1;
  localparam logic [1:0] EDIT_TIMER = 2'd2;

  localparam logic [N-1:0] SC_BREAK = N'(8'hF0);
  localparam logic [N-1:0] SC_EXT   = N'(8'hE0);
  localparam logic [N-1:0] SC_F1    = N'(8'h05);
  localparam logic [N-1:0] SC_F3    = N'(8'h04);
  localparam logic [N-1:0] SC_ESC   = N'(8'h76);
  localparam logic [N-1:0] SC_ENTER = N'(8'h5A);
  localparam logic [N-1:0] SC_RIGHT = N'(8'h74);
  localparam logic [N-1:0] SC_LEFT  = N'(8'h6B);
  localparam logic [N-1:0] SC_UP    = N'(8'h75);
  localparam logic [N-1:0] SC_DOWN  = N'(8'h72);

  localparam logic [P-1:0]  POS_LAST   = P'(NUM_POS - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  logic [1:0]    state, state_nxt;
  logic          brk, brk_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [P-1:0]  posicion_r, posicion_nxt;
  logic [N-1:0]  key_code_r, key_code_nxt;
  logic          en_codigo_r, en_codigo_nxt;
  logic          f1_r, f3_r;

  logic          is_prefix;
  logic          is_make;
  logic          in_edit;
  logic          timeout_hit;
  logic [P-1:0]  pos_inc;
  logic [P-1:0]  pos_dec;

  // A make code is any non-prefix byte that does not follow a break prefix.
  assign is_prefix   = (bus.rx_data == SC_BREAK) || (bus.rx_data == SC_EXT);
  assign is_make     = bus.rx_done && !is_prefix && !brk;
  assign in_edit     = (state == EDIT_RELOJ) || (state == EDIT_TIMER);
  assign timeout_hit = in_edit && (timer == TIMER_LAST);

  // Cursor moves wrap around the NUM_POS editable fields.
  assign pos_inc = (posicion_r == POS_LAST) ? '0 : posicion_r + P'(1);
  assign pos_dec = (posicion_r == '0) ? POS_LAST : posicion_r - P'(1);

  // Break-prefix tracker: F0 arms it, E0 leaves it alone, anything else consumes it.
  always_comb begin
    brk_nxt = brk;
    if (bus.rx_done) begin
      if (bus.rx_data == SC_BREAK) begin
        brk_nxt = 1'b1;
      end else if (bus.rx_data != SC_EXT) begin
        brk_nxt = 1'b0;
      end
    end
  end

  // Mode/cursor/stroke decision; a make code overrides the idle timeout in the same cycle.
  always_comb begin
    state_nxt     = in_edit ? state : IDLE;
    posicion_nxt  = posicion_r;
    timer_nxt     = '0;
    en_codigo_nxt = 1'b0;
    key_code_nxt  = key_code_r;

    if (in_edit) begin
      if (timeout_hit) begin
        state_nxt    = IDLE;
        posicion_nxt = '0;
      end else begin
        timer_nxt = timer + TW'(1);
      end
    end

    if (is_make) begin
      key_code_nxt = bus.rx_data;
      if (!in_edit) begin
        if (bus.rx_data == SC_F1) begin
          state_nxt    = EDIT_RELOJ;
          posicion_nxt = '0;
        end else if (bus.rx_data == SC_F3) begin
          state_nxt    = EDIT_TIMER;
          posicion_nxt = '0;
        end
      end else begin
        state_nxt    = state;
        posicion_nxt = posicion_r;
        timer_nxt    = '0;
        case (bus.rx_data)
          SC_F1: begin
            if (state == EDIT_TIMER) begin
              state_nxt    = EDIT_RELOJ;
              posicion_nxt = '0;
            end
          end
          SC_F3: begin
            if (state == EDIT_RELOJ) begin
              state_nxt    = EDIT_TIMER;
              posicion_nxt = '0;
            end
          end
          SC_ESC, SC_ENTER: begin
            state_nxt    = IDLE;
            posicion_nxt = '0;
          end
          SC_RIGHT: posicion_nxt  = pos_inc;
          SC_LEFT:  posicion_nxt  = pos_dec;
          SC_UP, SC_DOWN: en_codigo_nxt = 1'b1;
          default: ;
        endcase
      end
    end
  end

  // State and output registers; mode flags are decoded from the next state so they stay registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      brk         <= 1'b0;
      timer       <= '0;
      posicion_r  <= '0;
      key_code_r  <= '0;
      en_codigo_r <= 1'b0;
      f1_r        <= 1'b0;
      f3_r        <= 1'b0;
    end else begin
      state       <= state_nxt;
      brk         <= brk_nxt;
      timer       <= timer_nxt;
      posicion_r  <= posicion_nxt;
      key_code_r  <= key_code_nxt;
      en_codigo_r <= en_codigo_nxt;
      f1_r        <= (state_nxt == EDIT_RELOJ);
      f3_r        <= (state_nxt == EDIT_TIMER);
    end
  end

  assign bus.f1        = f1_r;
  assign bus.f3        = f3_r;
  assign bus.posicion  = posicion_r;
  assign bus.en_codigo = en_codigo_r;
  assign bus.key_code  = key_code_r;

endmodule

// File: tb/tb_ctrl_edicion_teclado.sv
// Bench for ctrl_edicion_teclado: directed scan-code sequences, a behavioural
// model compared every cycle, and literal expectations at key points.
module tb_ctrl_edicion_teclado;

  localparam int N       = 8;
  localparam int P       = 2;
  localparam int NUM_POS = 3;
  localparam int TW      = 30;
  localparam int TIMEOUT = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ctrl_edicion_teclado_if #(.N(N), .P(P)) bus ();

  ctrl_edicion_teclado #(
    .N(N), .P(P), .NUM_POS(NUM_POS), .TW(TW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model state: mode 0 = none, 1 = clock edit, 2 = timer edit.
  bit   model_valid = 1'b0;
  int   m_mode = 0;
  int   m_pos  = 0;
  bit   m_brk  = 1'b0;
  bit   m_en   = 1'b0;
  int   m_key  = 0;
  int   edge_no = 0;
  int   last_activity = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
    end
  endtask

  // Model reaction to one make code, expressed in terms of modes and field indices.
  task automatic model_make(input int code);
    m_key = code;
    if (m_mode == 0) begin
      if (code == 'h05) begin m_mode = 1; m_pos = 0; last_activity = edge_no; end
      else if (code == 'h04) begin m_mode = 2; m_pos = 0; last_activity = edge_no; end
    end else begin
      last_activity = edge_no;
      if (code == 'h05 && m_mode != 1) begin m_mode = 1; m_pos = 0; end
      else if (code == 'h04 && m_mode != 2) begin m_mode = 2; m_pos = 0; end
      else if (code == 'h76 || code == 'h5A) begin m_mode = 0; m_pos = 0; end
      else if (code == 'h74) m_pos = (m_pos + 1) % NUM_POS;
      else if (code == 'h6B) m_pos = (m_pos + NUM_POS - 1) % NUM_POS;
      else if (code == 'h75 || code == 'h72) m_en = 1'b1;
    end
  endtask

  // Model advances on each rising edge from the inputs that edge samples.
  always @(posedge clk) begin
    bit made;
    made = 1'b0;
    edge_no++;
    m_en = 1'b0;
    if (rst) begin
      m_mode = 0; m_pos = 0; m_brk = 1'b0; m_key = 0;
      model_valid = 1'b1;
    end else begin
      if (bus.rx_done) begin
        if (bus.rx_data == 8'hF0) m_brk = 1'b1;
        else if (bus.rx_data == 8'hE0) m_brk = m_brk;
        else if (m_brk) m_brk = 1'b0;
        else begin
          model_make(int'(bus.rx_data));
          made = 1'b1;
        end
      end
      if (!made && m_mode != 0 && (edge_no - last_activity) == TIMEOUT) begin
        m_mode = 0;
        m_pos  = 0;
      end
    end
  end

  // Continuous comparison of every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("model f1", 32'(bus.f1), 32'(m_mode == 1));
      checkOutput("model f3", 32'(bus.f3), 32'(m_mode == 2));
      checkOutput("model posicion", 32'(bus.posicion), 32'(m_pos));
      checkOutput("model en_codigo", 32'(bus.en_codigo), 32'(m_en));
      checkOutput("model key_code", 32'(bus.key_code), 32'(m_key));
    end
  end

  // One byte strobed for a single cycle; returns just after the edge that sampled it.
  task automatic applyStimulus(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_done = 1'b1;
    bus.rx_data = b;
    @(posedge clk); #1;
    bus.rx_done = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.rx_done = 1'b0;
    bus.rx_data = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    $display("[TB] reset released");
    checkOutput("reset f1", 32'(bus.f1), 0);
    checkOutput("reset f3", 32'(bus.f3), 0);
    checkOutput("reset posicion", 32'(bus.posicion), 0);
    checkOutput("reset en_codigo", 32'(bus.en_codigo), 0);
    checkOutput("reset key_code", 32'(bus.key_code), 0);

    // Enter clock edit and issue one up stroke
    applyStimulus(8'h05);
    checkOutput("f1 after F1", 32'(bus.f1), 1);
    checkOutput("pos after F1", 32'(bus.posicion), 0);
    applyStimulus(8'h75);
    checkOutput("up pulse", 32'(bus.en_codigo), 1);
    checkOutput("up key_code", 32'(bus.key_code), 32'h75);
    wait_cycles(1);
    checkOutput("up pulse width", 32'(bus.en_codigo), 0);

    // Cursor movement with wrap in both directions
    applyStimulus(8'h74);
    checkOutput("cursor 1", 32'(bus.posicion), 1);
    applyStimulus(8'h74);
    checkOutput("cursor 2", 32'(bus.posicion), 2);
    applyStimulus(8'h74);
    checkOutput("cursor wrap up", 32'(bus.posicion), 0);
    applyStimulus(8'h6B);
    checkOutput("cursor wrap down", 32'(bus.posicion), 2);
    checkOutput("cursor no pulse", 32'(bus.en_codigo), 0);

    // Release sequence is swallowed; extended prefix is transparent
    applyStimulus(8'hF0);
    applyStimulus(8'h75);
    checkOutput("release no pulse", 32'(bus.en_codigo), 0);
    checkOutput("release key kept", 32'(bus.key_code), 32'h6B);
    applyStimulus(8'hE0);
    applyStimulus(8'h72);
    checkOutput("ext down pulse", 32'(bus.en_codigo), 1);
    checkOutput("ext down key", 32'(bus.key_code), 32'h72);

    // Mode switch and exit
    applyStimulus(8'h04);
    checkOutput("switch f1", 32'(bus.f1), 0);
    checkOutput("switch f3", 32'(bus.f3), 1);
    checkOutput("switch pos", 32'(bus.posicion), 0);
    applyStimulus(8'h04);
    checkOutput("same F key keeps f3", 32'(bus.f3), 1);
    applyStimulus(8'h76);
    checkOutput("esc f1", 32'(bus.f1), 0);
    checkOutput("esc f3", 32'(bus.f3), 0);

    // Idle timeout, then a key landing exactly on the timeout cycle
    applyStimulus(8'h05);
    wait_cycles(TIMEOUT - 1);
    checkOutput("before timeout", 32'(bus.f1), 1);
    wait_cycles(1);
    checkOutput("timeout exit", 32'(bus.f1), 0);
    applyStimulus(8'h05);
    wait_cycles(TIMEOUT - 2);
    applyStimulus(8'h75);
    checkOutput("key on timeout pulse", 32'(bus.en_codigo), 1);
    checkOutput("key on timeout stays", 32'(bus.f1), 1);
    wait_cycles(TIMEOUT - 1);
    checkOutput("timer restarted", 32'(bus.f1), 1);
    wait_cycles(1);
    checkOutput("second timeout", 32'(bus.f1), 0);

    // Strokes and cursor keys have no effect in IDLE
    applyStimulus(8'h75);
    checkOutput("idle up no pulse", 32'(bus.en_codigo), 0);
    applyStimulus(8'h72);
    checkOutput("idle down no pulse", 32'(bus.en_codigo), 0);
    applyStimulus(8'h74);
    checkOutput("idle cursor", 32'(bus.posicion), 0);
    checkOutput("idle key loads", 32'(bus.key_code), 32'h74);

    // Back-to-back bytes in timer edit
    applyStimulus(8'h04);
    @(posedge clk); #1;
    bus.rx_done = 1'b1;
    bus.rx_data = 8'h74;
    @(posedge clk); #1;
    bus.rx_data = 8'h74;
    @(posedge clk); #1;
    bus.rx_done = 1'b0;
    checkOutput("burst cursor", 32'(bus.posicion), 2);
    applyStimulus(8'h5A);
    checkOutput("enter exit", 32'(bus.f3), 0);

    // Reset mid-edit with a pending break prefix
    applyStimulus(8'h05);
    applyStimulus(8'h74);
    applyStimulus(8'hF0);
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    checkOutput("mid rst f1", 32'(bus.f1), 0);
    checkOutput("mid rst pos", 32'(bus.posicion), 0);
    checkOutput("mid rst key", 32'(bus.key_code), 0);
    applyStimulus(8'h05);
    checkOutput("brk lost on rst", 32'(bus.f1), 1);
    wait_cycles(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
